// File: rtl/ce_gen_multi.sv
// Multi-channel fractional clock-enable generator: each channel emits one-cycle
// strobes at an average rate of num/den of clk_sys, plus a square wave toggling per strobe.
module ce_gen_multi #(
    parameter int unsigned         N_CH    = 4,
    parameter int unsigned         W       = 16,
    parameter logic [N_CH*W-1:0]   RST_NUM = {N_CH{W'(1)}},
    parameter logic [N_CH*W-1:0]   RST_DEN = {N_CH{W'(10)}}
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            run,
    input  logic            restart,
    input  logic            cfg_we,
    input  logic [3:0]      cfg_ch,
    input  logic [W-1:0]    cfg_num,
    input  logic [W-1:0]    cfg_den,
    output logic [N_CH-1:0] ce,
    output logic [N_CH-1:0] sq,
    output logic            busy
);

    logic [W-1:0]    num_q [N_CH];
    logic [W-1:0]    num_d [N_CH];
    logic [W-1:0]    den_q [N_CH];
    logic [W-1:0]    den_d [N_CH];
    logic [W:0]      acc_q [N_CH];
    logic [W:0]      acc_d [N_CH];
    logic [N_CH-1:0] ce_q, ce_d;
    logic [N_CH-1:0] sq_q, sq_d;
    logic            busy_q, busy_d;
    logic            wr_ok;

    always_comb begin
        logic [W:0] sum;
        logic       wr_hit;
        sum    = '0;
        wr_hit = 1'b0;
        wr_ok  = cfg_we && ({1'b0, cfg_ch} < 5'(N_CH));
        busy_d = wr_ok || restart;
        ce_d   = '0;
        sq_d   = sq_q;
        for (int i = 0; i < N_CH; i++) begin
            num_d[i] = num_q[i];
            den_d[i] = den_q[i];
            acc_d[i] = acc_q[i];
            wr_hit   = wr_ok && (cfg_ch == 4'(i));
            // acc < den < 2^W and num < 2^W, so the W+1 bit sum cannot wrap
            sum      = acc_q[i] + {1'b0, num_q[i]};
            if (restart || wr_hit) begin
                if (wr_hit) begin
                    num_d[i] = cfg_num;
                    den_d[i] = cfg_den;
                end
                acc_d[i] = '0;
                sq_d[i]  = 1'b0;
            end else if (run) begin
                if (den_q[i] == '0 || num_q[i] == '0) begin
                    ce_d[i] = 1'b0;
                end else if (num_q[i] >= den_q[i]) begin
                    ce_d[i]  = 1'b1;
                    acc_d[i] = '0;
                end else if (sum >= {1'b0, den_q[i]}) begin
                    ce_d[i]  = 1'b1;
                    acc_d[i] = sum - {1'b0, den_q[i]};
                end else begin
                    acc_d[i] = sum;
                end
                sq_d[i] = sq_q[i] ^ ce_d[i];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                num_q[i] <= RST_NUM[i*W +: W];
                den_q[i] <= RST_DEN[i*W +: W];
                acc_q[i] <= '0;
            end
            ce_q   <= '0;
            sq_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                num_q[i] <= num_d[i];
                den_q[i] <= den_d[i];
                acc_q[i] <= acc_d[i];
            end
            ce_q   <= ce_d;
            sq_q   <= sq_d;
            busy_q <= busy_d;
        end
    end

    assign ce   = ce_q;
    assign sq   = sq_q;
    assign busy = busy_q;

endmodule
